vc_arb_requester: RTL

- Requester-side endpoint for the ring network's round-robin and variable arbiters.
- Buffers outgoing messages in a small FIFO and drives one req bit into an arbiter's reqs vector.
- Consumes the matching grants bit, dequeues the head message, and launches it one cycle later.
- Tracks cycles spent waiting for a grant; a security domain input labels all data-bearing signals.

---
 rtl/vc_arb_requester_pkg.sv | 15 +
 rtl/vc_arb_req_fifo.sv | 58 +++++
 rtl/vc_arb_requester.sv | 81 ++++++++
 3 files changed

// File: rtl/vc_arb_requester_pkg.sv
// Shared constants and helpers for the arbiter requester endpoint.
package vc_arb_requester_pkg;

  localparam int VC_ARB_MAX_WAIT_DEFAULT = 15;
  localparam int VC_ARB_CNT_NBITS        = 8;

  // Pointer width for a buffer of n entries (n >= 2).
  function automatic int vc_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/vc_arb_req_fifo.sv
// Small circular buffer holding messages waiting for an arbiter grant.
module vc_arb_req_fifo
  import vc_arb_requester_pkg::*;
#(
  parameter int p_msg_nbits = 32,
  parameter int p_depth     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val_i,
  input  logic [p_msg_nbits-1:0] enq_msg_i,
  output logic                   enq_rdy_o,
  input  logic                   deq_i,
  output logic [p_msg_nbits-1:0] head_msg_o,
  output logic                   not_empty_o
);

  localparam int AW    = vc_clog2(p_depth);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(p_depth);

  logic [p_depth-1:0][p_msg_nbits-1:0] mem_q;
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enq, deq;

  // Held off during reset so nothing is admitted while state is being cleared.
  assign enq_rdy_o   = !reset && (cnt_q != CntFull);
  assign not_empty_o = (cnt_q != '0);
  assign head_msg_o  = mem_q[rd_q];

  assign enq = enq_val_i && enq_rdy_o;
  assign deq = deq_i && not_empty_o;

  always_comb begin
    wr_d  = enq ? wr_q + AW'(1) : wr_q;
    rd_d  = deq ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(deq);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_q] <= enq_msg_i;
  end

endmodule

// File: rtl/vc_arb_requester.sv
// Requester endpoint: buffers messages, requests an arbiter, launches on grant,
// and tracks how long the head has been waiting.
module vc_arb_requester
  import vc_arb_requester_pkg::*;
#(
  parameter int p_msg_nbits = 32,
  parameter int p_depth     = 4,
  parameter int p_max_wait  = VC_ARB_MAX_WAIT_DEFAULT,
  parameter int p_cnt_nbits = VC_ARB_CNT_NBITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   domain,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   req,
  input  logic                   grant,
  output logic                   out_val,
  output logic [p_msg_nbits-1:0] out_msg,
  output logic [p_cnt_nbits-1:0] wait_count,
  output logic                   starved
);

  logic                   not_empty, deq;
  logic [p_msg_nbits-1:0] head_msg;
  logic                   out_val_q;
  logic [p_msg_nbits-1:0] out_msg_q, out_msg_d;
  logic [p_cnt_nbits-1:0] wait_q, wait_d;
  logic                   starved_q, starved_d;

  // Domain only labels the data; nothing here depends on it.
  logic unused_domain;
  assign unused_domain = domain;

  vc_arb_req_fifo #(
    .p_msg_nbits(p_msg_nbits),
    .p_depth    (p_depth)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .enq_val_i  (enq_val),
    .enq_msg_i  (enq_msg),
    .enq_rdy_o  (enq_rdy),
    .deq_i      (deq),
    .head_msg_o (head_msg),
    .not_empty_o(not_empty)
  );

  assign req = not_empty;
  assign deq = not_empty && grant;

  always_comb begin
    out_msg_d = deq ? head_msg : out_msg_q;
    wait_d    = wait_q;
    if (!req || deq)      wait_d = '0;
    else if (wait_q != '1) wait_d = wait_q + p_cnt_nbits'(1);
    // Sticky: set on the cycle the count lands on the limit.
    starved_d = starved_q || (wait_d == p_cnt_nbits'(p_max_wait));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      wait_q    <= '0;
      starved_q <= 1'b0;
    end else begin
      out_val_q <= deq;
      out_msg_q <= out_msg_d;
      wait_q    <= wait_d;
      starved_q <= starved_d;
    end
  end

  assign out_val    = out_val_q;
  assign out_msg    = out_msg_q;
  assign wait_count = wait_q;
  assign starved    = starved_q;

endmodule
